// File: rtl/ste_snd_dma.sv
// ste_snd_dma: sound DMA frame sequencer, slot requester and sample FIFO.
// Optional stereo drain is enabled by defining SND_DMA_STEREO_EN.
//
// Ports:
//   clk, porb        clock, async active-low reset
//   sndon            DMA enable level; low aborts and flushes
//   sfrep            frame repeat, sampled at frame end
//   stereo           1 = word holds L/R, 0 = word holds two mono samples
//   sft, sfe         frame start / exclusive end word address
//   sreq             registered memory slot request
//   sload, sdata     grant strobe and fetched word
//   snd              current fetch word address
//   stick            sample tick from the rate divider
//   samp_l, samp_r   signed 8-bit output samples
//   sframe           high while fetching a frame
//   sint             one-cycle end-of-frame pulse
//   underrun         sticky: tick seen with FIFO empty
module ste_snd_dma #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        porb,
  input  logic        sndon,
  input  logic        sfrep,
  input  logic        stereo,
  input  logic [20:0] sft,
  input  logic [20:0] sfe,
  output logic        sreq,
  input  logic        sload,
  input  logic [15:0] sdata,
  output logic [20:0] snd,
  input  logic        stick,
  output logic [7:0]  samp_l,
  output logic [7:0]  samp_r,
  output logic        sframe,
  output logic        sint,
  output logic        underrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          phase;
  logic          empty, full;
  logic          stereo_mode;
  logic          push, pop, frame_end;
  logic          d_under, d_lo, d_st, d_hi;
  logic [15:0]   head;
  logic [20:0]   snd_inc;

`ifdef SND_DMA_STEREO_EN
  assign stereo_mode = stereo;
`else
  logic unused_stereo;
  assign unused_stereo = stereo;
  assign stereo_mode   = 1'b0;
`endif

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign head    = mem[rd_ptr];
  assign snd_inc = snd + 21'd1;

  // Mode is only re-evaluated at a word boundary (phase == 0),
  // so a pending mono low byte always completes first.
  assign d_under = sndon && stick && empty;
  assign d_lo    = sndon && stick && !empty && phase;
  assign d_st    = sndon && stick && !empty && !phase && stereo_mode;
  assign d_hi    = sndon && stick && !empty && !phase && !stereo_mode;

  assign pop  = d_lo || d_st;
  // A full FIFO still takes the word when a pop frees a slot now.
  assign push = (state == RUN) && sndon && sload && (!full || pop);
  assign frame_end = push && (snd_inc == sfe);

  assign count_nx = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sndon) state_nx = (sft == sfe) ? STOP : RUN;
      RUN:     if (frame_end && !sfrep) state_nx = STOP;
      STOP:    state_nx = STOP;
      default: state_nx = IDLE;
    endcase
    if (!sndon) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sdata;
  end

  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      state    <= IDLE;
      sreq     <= 1'b0;
      snd      <= '0;
      sframe   <= 1'b0;
      sint     <= 1'b0;
      underrun <= 1'b0;
      samp_l   <= '0;
      samp_r   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      phase    <= 1'b0;
    end else begin
      state  <= state_nx;
      sframe <= (state_nx == RUN);
      sint   <= 1'b0;
      if (!sndon) begin
        sreq     <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        phase    <= 1'b0;
        underrun <= 1'b0;
      end else begin
        // Request only while fetching now and still fetching next.
        sreq  <= (state == RUN) && (state_nx == RUN)
                 && (count_nx < DEPTH_C);
        count <= count_nx;
        if (state == IDLE) begin
          snd  <= sft;
          sint <= (sft == sfe);
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          snd    <= (frame_end && sfrep) ? sft : snd_inc;
          sint   <= frame_end;
        end
        unique case (1'b1)
          d_under: underrun <= 1'b1;
          d_lo: begin
            samp_l <= head[7:0];
            samp_r <= head[7:0];
            phase  <= 1'b0;
            rd_ptr <= rd_ptr + AW'(1);
          end
          d_st: begin
            samp_l <= head[15:8];
            samp_r <= head[7:0];
            rd_ptr <= rd_ptr + AW'(1);
          end
          d_hi: begin
            samp_l <= head[15:8];
            samp_r <= head[15:8];
            phase  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ste_snd_dma.sv
// tb_ste_snd_dma: directed bench for ste_snd_dma with a queue-based
// reference model compared on every falling clock edge.
module tb_ste_snd_dma;

  localparam int DEPTH = 4;
`ifdef SND_DMA_STEREO_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        porb = 1'b0;
  logic        sndon = 1'b0;
  logic        sfrep = 1'b0;
  logic        stereo = 1'b0;
  logic [20:0] sft = '0;
  logic [20:0] sfe = '0;
  logic        sload = 1'b0;
  logic [15:0] sdata = '0;
  logic        stick = 1'b0;
  logic        sreq, sframe, sint, underrun;
  logic [20:0] snd;
  logic [7:0]  samp_l, samp_r;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ste_snd_dma #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .porb(porb), .sndon(sndon), .sfrep(sfrep),
    .stereo(stereo), .sft(sft), .sfe(sfe), .sreq(sreq),
    .sload(sload), .sdata(sdata), .snd(snd), .stick(stick),
    .samp_l(samp_l), .samp_r(samp_r), .sframe(sframe),
    .sint(sint), .underrun(underrun)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: frame as a fetching/finished pair, FIFO as a queue.
  logic [15:0] q[$];
  bit          fetching = 0, finished = 0, half = 0;
  logic [20:0] e_snd = '0;
  logic [7:0]  e_l = '0, e_r = '0;
  bit          e_sreq = 0, e_sframe = 0, e_sint = 0, e_under = 0;

  task automatic model_reset();
    q.delete();
    fetching = 0; finished = 0; half = 0;
    e_snd = '0; e_l = '0; e_r = '0;
    e_sreq = 0; e_sframe = 0; e_sint = 0; e_under = 0;
  endtask

  task automatic model_step();
    bit was, ns;
    logic [15:0] w;
    was = fetching;
    ns = 0;
    if (!sndon) begin
      fetching = 0; finished = 0; half = 0; q.delete();
      e_under = 0; e_sreq = 0; e_sframe = 0; e_sint = 0;
      return;
    end
    if (stick) begin
      if (q.size() == 0) e_under = 1;
      else begin
        w = q[0];
        if (half) begin
          e_l = w[7:0]; e_r = w[7:0]; half = 0;
          void'(q.pop_front());
        end else if (ST_EN && stereo) begin
          e_l = w[15:8]; e_r = w[7:0];
          void'(q.pop_front());
        end else begin
          e_l = w[15:8]; e_r = w[15:8]; half = 1;
        end
      end
    end
    if (!fetching && !finished) begin
      e_snd = sft;
      if (sft == sfe) begin finished = 1; ns = 1; end
      else fetching = 1;
    end else if (fetching && sload && q.size() < DEPTH) begin
      q.push_back(sdata);
      if (e_snd + 21'd1 == sfe) begin
        ns = 1;
        if (sfrep) e_snd = sft;
        else begin
          e_snd = e_snd + 21'd1; fetching = 0; finished = 1;
        end
      end else e_snd = e_snd + 21'd1;
    end
    e_sreq = was && fetching && (q.size() < DEPTH);
    e_sframe = fetching;
    e_sint = ns;
  endtask

  always @(posedge clk or negedge porb) begin
    if (!porb) model_reset();
    else model_step();
  end

  int n_sint = 0, n_sint_sft = 0, n_sreq = 0;

  always @(negedge clk) begin
    chk("sreq", sreq, e_sreq);
    chk("snd", snd, e_snd);
    chk("sframe", sframe, e_sframe);
    chk("sint", sint, e_sint);
    chk("underrun", underrun, e_under);
    chk("samp_l", samp_l, e_l);
    chk("samp_r", samp_r, e_r);
    if (sint) begin
      n_sint++;
      if (snd == sft) n_sint_sft++;
    end
    if (sreq) n_sreq++;
  end

  // Grants each visible request while words remain in the list.
  bit          auto_grant = 0;
  logic [15:0] gw[$];

  always @(negedge clk) begin
    if (auto_grant && sreq && gw.size() > 0) begin
      sload = 1'b1;
      sdata = gw.pop_front();
    end else begin
      sload = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk); stick = 1'b1;
    @(negedge clk); stick = 1'b0;
  endtask

  task automatic wait_grants(input string name);
    for (int i = 0; i < 60 && gw.size() > 0; i++) @(negedge clk);
    chk(name, gw.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    porb = 1'b0;
    sndon = 1'b0;
    @(negedge clk); #2;
    porb = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b_sint, b_sft, b_sreq;

    #12;
    chk("rst_sreq", sreq, 0);
    chk("rst_snd", snd, 0);
    chk("rst_sframe", sframe, 0);
    chk("rst_sint", sint, 0);
    chk("rst_under", underrun, 0);
    chk("rst_samp", {samp_l, samp_r}, 0);
    @(negedge clk); #2;
    porb = 1'b1;

    // Mono single frame
    @(negedge clk);
    sft = 21'h100; sfe = 21'h102; sfrep = 0; stereo = 0;
    gw = '{16'h1122, 16'h3344};
    b_sint = n_sint;
    auto_grant = 1; sndon = 1;
    cyc(2);
    chk("first_sreq", sreq, 1);
    cyc(6);
    chk("t1_sint_cnt", n_sint - b_sint, 1);
    chk("t1_snd", snd, 21'h102);
    chk("t1_sreq", sreq, 0);
    chk("t1_sframe", sframe, 0);
    tick(); chk("t1_s0", {samp_l, samp_r}, 16'h1111);
    tick(); chk("t1_s1", {samp_l, samp_r}, 16'h2222);
    tick(); chk("t1_s2", {samp_l, samp_r}, 16'h3333);
    tick(); chk("t1_s3", {samp_l, samp_r}, 16'h4444);
    chk("t1_under", underrun, 0);
    sndon = 0;
    cyc(2);

    // Frame repeat
    sft = 21'h200; sfe = 21'h203; sfrep = 1;
    gw = '{16'h0102, 16'h0304, 16'h0506, 16'h0708,
           16'h090a, 16'h0b0c, 16'h0d0e};
    b_sint = n_sint; b_sft = n_sint_sft;
    sndon = 1; stick = 1;
    wait_grants("t2_grants");
    cyc(3);
    stick = 0;
    chk("t2_sint_cnt", n_sint - b_sint, 2);
    chk("t2_sint_sft", n_sint_sft - b_sft, 2);
    chk("t2_snd", snd, 21'h201);
    chk("t2_sframe", sframe, 1);
    sndon = 0; sfrep = 0;
    cyc(2);

    // Backpressure
    sft = 21'h400; sfe = 21'h480; stereo = 1;
    gw = '{16'h1001, 16'h2002, 16'h3003, 16'h4004,
           16'h5005, 16'h6006, 16'h7007, 16'h8008};
    sndon = 1;
    cyc(12);
    chk("t3_sreq_low", sreq, 0);
    chk("t3_snd", snd, 21'h404);
`ifdef SND_DMA_STEREO_EN
    tick();
`else
    tick();
    tick();
`endif
    chk("t3_sreq_up", sreq, 1);
    auto_grant = 0;
    gw.delete();
    sndon = 0; stereo = 0;
    cyc(2);

    // Underrun
    pulse_reset();
    @(negedge clk);
    sft = 21'h500; sfe = 21'h510;
    sndon = 1;
    cyc(2);
    tick(); tick(); tick();
    chk("t4_under", underrun, 1);
    chk("t4_samp", {samp_l, samp_r}, 0);
    sndon = 0;
    cyc(2);
    chk("t4_under_clr", underrun, 0);
    chk("t4_sreq", sreq, 0);

    // Abort and reset mid-frame
    sft = 21'h600; sfe = 21'h620;
    gw = '{16'h6161, 16'h6262};
    auto_grant = 1; sndon = 1;
    wait_grants("t5_grants");
    sndon = 0;
    cyc(1);
    chk("t5_sreq", sreq, 0);
    chk("t5_sframe", sframe, 0);
    gw = '{16'h6363, 16'h6464};
    sndon = 1;
    cyc(6);
    chk("t5_run", sframe, 1);
    pulse_reset_check();

    // Empty frame
    @(negedge clk);
    sft = 21'h300; sfe = 21'h300; stereo = 1;
    b_sint = n_sint; b_sreq = n_sreq;
    sndon = 1;
    cyc(5);
    chk("t6_sint_cnt", n_sint - b_sint, 1);
    chk("t6_no_sreq", n_sreq - b_sreq, 0);
    chk("t6_sframe", sframe, 0);
    sndon = 0;
    cyc(2);

    // Drain mode with stereo input high
    sft = 21'h700; sfe = 21'h701;
    gw = '{16'haabb};
    sndon = 1;
    wait_grants("t7_grants");
    cyc(2);
`ifdef SND_DMA_STEREO_EN
    tick(); chk("t7_st", {samp_l, samp_r}, 16'haabb);
`else
    tick(); chk("t7_hi", {samp_l, samp_r}, 16'haaaa);
    tick(); chk("t7_lo", {samp_l, samp_r}, 16'hbbbb);
`endif
    sndon = 0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic pulse_reset_check();
    @(posedge clk); #2;
    porb = 1'b0;
    sndon = 1'b0;
    #1;
    chk("por_snd", snd, 0);
    chk("por_sreq", sreq, 0);
    chk("por_sframe", sframe, 0);
    chk("por_sint", sint, 0);
    chk("por_samp", {samp_l, samp_r}, 0);
    chk("por_under", underrun, 0);
    @(negedge clk); #2;
    porb = 1'b1;
  endtask

endmodule

// File: doc/ste_snd_dma.md
# ste_snd_dma

DMA sound frame sequencer for the MCU: owns the sound frame address counter, requests memory slots from the bus-cycle control logic, and buffers fetched sound words in a small FIFO. The audio DAC path drains the FIFO one sample per sample tick. It handles frame start/end, frame repeat, and the end-of-frame interrupt (sint). It sits between the CPU-visible sound registers (frame start/end, mode) and the shared memory slot scheduler.

## Interface
- FIFO_DEPTH, 4: sound FIFO depth in 16-bit words; power of two, 2..8.
- clk  in  1  master clock; all state changes on rising edge.
- porb  in  1  asynchronous active-low reset.
- sndon  in  1  DMA enable level; low aborts immediately.
- sfrep  in  1  frame repeat; sampled at each frame end.
- stereo  in  1  1 = stereo (word = L/R), 0 = mono (word = two samples).
- sft  in  21  frame start word address [21:1].
- sfe  in  21  frame end word address [21:1], exclusive.
- sreq  out  1  memory slot request, registered.
- sload  in  1  one-cycle grant strobe; sdata valid this cycle.
- sdata  in  16  fetched word.
- snd  out  21  current fetch word address.
- stick  in  1  one-cycle sample tick from the sample-rate divider.
- samp_l  out  8  left/mono sample, signed.
- samp_r  out  8  right sample, signed.
- sframe  out  1  high while a frame is being fetched.
- sint  out  1  one-cycle end-of-frame pulse.
- underrun  out  1  sticky: tick seen with FIFO empty.

## Operation
- States: IDLE, RUN, STOP.
- IDLE: snd = sft is loaded when sndon is high. Go to RUN, or to STOP if sft == sfe; in that case pulse sint and fetch nothing.
- RUN: sreq is high when FIFO occupancy after this cycle is < FIFO_DEPTH.
- On sload with FIFO not full: push sdata and set snd <= snd + 1, with 21-bit wrap.
- On sload with FIFO full: word dropped, snd unchanged. This is a bench error condition.
- Frame end: snd + 1 == sfe on an accepted sload. Pulse sint in the next cycle.
  - If sfrep = 1: snd <= sft (current sft), stay in RUN.
  - Else: go to STOP with sreq low.
- STOP: fetching is finished. The FIFO keeps draining on stick. Return to IDLE only when sndon goes low.
- sndon low in any state: IDLE next cycle. sreq low, FIFO flushed, byte phase cleared, underrun cleared. samp_l/samp_r hold their values.
- Drain, mono: each word holds two samples, high byte first. Both samp_l and samp_r take the byte. The pop happens on the second byte.
- Drain, stereo: one tick pops one word; samp_l = [15:8], samp_r = [7:0].
- Drain, empty FIFO on a tick: samples hold, underrun set.
- Push and pop in the same cycle: both take effect, occupancy unchanged. A push into a full FIFO with a simultaneous pop is accepted.
- A stereo change is honoured at the next word boundary only.

## Timing
- Reset values:
  - state IDLE; sreq 0; snd 0; sframe 0; sint 0; underrun 0.
  - samp_l 0; samp_r 0; FIFO empty; byte phase 0.
- sndon rising edge to first sreq: 2 cycles (IDLE→RUN, then registered sreq).
- sload to FIFO data visible to the drain: 1 cycle.
- stick to sample update: 1 cycle (registered outputs).
- sint: exactly 1 cycle, one cycle after the frame-ending sload.
- sframe: equals state == RUN, registered.
- sreq drops the cycle after the sload that fills the FIFO. A grant in the same cycle sreq is computed low is accepted if space exists.
- porb assertion mid-frame: all outputs to reset values asynchronously.

## Configuration
- SND_DMA_STEREO_EN:
  - Defined: the stereo input selects the drain mode as described.
  - Undefined: stereo is ignored, mono-only drain, samp_r always equals samp_l, and the stereo logic is not synthesised.

## Test plan
- Mono single frame: sft=0x100, sfe=0x102, sfrep=0; grant every request with words 0x1122, 0x3344; 4 ticks.
  - Response: snd 0x100→0x102, one sint, STOP, sreq low.
  - Samples 0x11, 0x22, 0x33, 0x44; underrun stays 0.
- Repeat: sft=0x200, sfe=0x203, sfrep=1, 7 grants.
  - Response: sint after grants 3 and 6; snd returns to 0x200 both times; state stays RUN.
- FIFO backpressure: FIFO_DEPTH=4, no ticks, continuous grants.
  - Response: sreq drops after the 4th accepted word, snd = sft+4.
  - One tick in stereo re-raises sreq within 2 cycles.
- Underrun: start a frame, issue 3 ticks before any grant.
  - Response: underrun=1, samples hold 0.
  - sndon low clears underrun and flushes the FIFO.
- Abort/reset mid-frame: sndon low after 2 grants → IDLE next cycle, sreq 0, sframe 0. porb pulse mid-frame → all reset values immediately.
- Empty frame: sft=sfe=0x300 → one sint, STOP, no sreq ever. With SND_DMA_STEREO_EN undefined and stereo=1, word 0xAABB → samples 0xAA, then 0xBB on both channels.
